stack_drain: RTL
================

// Module: stack_drain
// PURPOSE
//  Read-side controller for the Stack block: on a start pulse, pops every entry until empty.
//  Paces pops at one per HOLD_CYCLES so each value stays visible on LEDs.
//  Sits between a debounced button and the Stack's pop/empty/r_data port.
//  Complements the push-side user input path.
// PARAMETERS
//  B            3          data width, matches Stack B
//  W            2          Stack address bits; stack depth is 2^W
//  HOLD_CYCLES  6_000_000  clk cycles each popped value is held (0.5 s at 12 MHz); must be >= 2
//  TW           23         hold timer width; 2^TW must be >= HOLD_CYCLES
// PORTS
//  clk            in   1    system clock
//  reset          in   1    synchronous, active-high reset
//  start          in   1    one-cycle pulse from debouncer; begins a drain
//  stack_empty    in   1    Stack empty flag
//  stack_r_data   in   B    Stack top-of-stack data (combinational from Stack)
//  stack_pop      out  1    one-cycle pop strobe to Stack
//  data_out       out  B    last popped value (registered)
//  data_valid     out  1    data_out holds a value popped in the current/last drain
//  count          out  W+1  number of entries popped in current/last drain (0..2^W)
//  busy           out  1    drain in progress (any state except IDLE)
//  done_tick      out  1    one-cycle pulse when a drain finishes
// BEHAVIOUR
//  - Clock and reset
//    - One clock. Reset is synchronous and active-high.
//    - Reset: state=IDLE; data_out=0, data_valid=0, count=0, stack_pop=0, done_tick=0, timer=0.
//    - Reset mid-drain: abandons the drain with no further pop. Entries already popped stay removed.
//  - FSM states: IDLE, POP, HOLD, DONE. Outputs are Moore, decoded from state and registers.
//    - IDLE, busy=0:
//      - start=1: count<=0, data_valid<=0.
//      - Then stack_empty=0 -> POP; stack_empty=1 -> DONE.
//    - POP, busy=1: stack_pop=1 for exactly this cycle.
//      - data_out<=stack_r_data, data_valid<=1, count<=count+1, timer<=0.
//      - Next state is HOLD.
//    - HOLD, busy=1: timer increments each cycle.
//      - At timer==HOLD_CYCLES-1: stack_empty=0 -> POP; stack_empty=1 -> DONE.
//      - stack_empty is sampled only at that point, after the Stack has registered the pop.
//    - DONE, busy=1: done_tick=1 for this cycle only; next state is IDLE.
//  - Timing and latency
//    - Pop strobe is 1 cycle after start. Pop-to-pop spacing is HOLD_CYCLES+1 cycles.
//    - done_tick comes 1 cycle after HOLD expires on empty. For a start with the stack already empty, done_tick comes 1 cycle after start.
//  - start is ignored while busy=1. A start coinciding with reset is ignored.
//  - count never exceeds 2^W; no wrap handling is needed.
//  - data_out/count hold their final values after DONE until the next start or reset.
//  - External pushes during a drain are legal; they are drained too, since emptiness is re-checked each HOLD.
//  - stack_pop is never asserted when stack_empty was 1 at the decision point.
// STRUCTURE
//  - Shared package/header: state encodings (IDLE/POP/HOLD/DONE, 2 bits) and default HOLD_CYCLES for the 12 MHz board clock.
//  - Sub-module hold_timer: mod-HOLD_CYCLES counter with clear input and expiry tick output. Reusable by other LED pacing blocks.
//  - Top-level test wrapper (separate file) connects Debounce -> stack_drain -> Stack -> LEDs.
// TESTING  (bench uses HOLD_CYCLES=4)
//  1. Reset with stack holding 5,2,7 -> all outputs 0, state IDLE; release reset -> no pop.
//  2. Push 1,2,3; pulse start -> pops every 5 cycles.
//     - data_out sequence 3,2,1; count 1,2,3.
//     - done_tick once, 5 cycles after the last pop.
//     - Final busy=0, data_out=3'd1, count=3.
//  3. Stack empty; pulse start -> no stack_pop; done_tick 1 cycle later; count=0; data_valid=0.
//  4. Fill to full (4 entries); start -> exactly 4 pops; count=3'd4.
//     - Pulse start again mid-drain -> ignored, count still ends at 4.
//  5. Push 6; start; assert reset during HOLD -> IDLE, count=0, no further stack_pop.
//     - Stack reset behaviour is per the Stack block.
//  6. Push 4; start; push 5 during HOLD -> second pop yields 5; count=2; done_tick after.

Source files
------------

// File: rtl/stack_drain_pkg.sv
// Shared definitions for the stack drain controller and its hold timer.
package stack_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // 0.5 s per value on the 12 MHz board clock
    localparam int unsigned DEFAULT_HOLD_CYCLES = 6_000_000;
    localparam int unsigned DEFAULT_TW          = 23;

endpackage

// File: rtl/stack_drain_hold_timer.sv
// Mod-HOLD_CYCLES pacing counter with synchronous clear and an expiry tick.
module hold_timer
    import stack_drain_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned TW          = DEFAULT_TW
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam logic [TW-1:0] LAST = TW'(HOLD_CYCLES - 1);

    logic [TW-1:0] timer;

    assign expire_c = enable && (timer == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            timer <= '0;
        end else if (enable) begin
            timer <= expire_c ? '0 : timer + TW'(1);
        end
    end

endmodule

// File: rtl/stack_drain.sv
// Read-side stack controller: on start, pops every entry, holding each for HOLD_CYCLES.
module stack_drain
    import stack_drain_pkg::*;
#(
    parameter int unsigned B           = 3,
    parameter int unsigned W           = 2,
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned TW          = DEFAULT_TW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stack_empty,
    input  logic [B-1:0] stack_r_data,
    output logic         stack_pop,
    output logic [B-1:0] data_out,
    output logic         data_valid,
    output logic [W:0]   count,
    output logic         busy,
    output logic         done_tick
);

    localparam int unsigned CW = W + 1;

    state_t state;
    logic   expire_c;
    logic   timer_clear;
    logic   timer_enable;

    assign timer_clear  = (state == POP);
    assign timer_enable = (state == HOLD);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .TW          (TW)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .expire_c (expire_c)
    );

    // Strobes and busy are set alongside the transition so they line up with the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            data_out   <= '0;
            data_valid <= 1'b0;
            count      <= '0;
            stack_pop  <= 1'b0;
            done_tick  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            stack_pop <= 1'b0;
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count      <= '0;
                        data_valid <= 1'b0;
                        busy       <= 1'b1;
                        if (stack_empty) begin
                            state     <= DONE;
                            done_tick <= 1'b1;
                        end else begin
                            state     <= POP;
                            stack_pop <= 1'b1;
                        end
                    end
                end
                POP: begin
                    data_out   <= stack_r_data;
                    data_valid <= 1'b1;
                    count      <= count + CW'(1);
                    state      <= HOLD;
                end
                HOLD: begin
                    // Emptiness is only trusted once the previous pop has settled in the Stack.
                    if (expire_c) begin
                        if (stack_empty) begin
                            state     <= DONE;
                            done_tick <= 1'b1;
                        end else begin
                            state     <= POP;
                            stack_pop <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
